// File: rtl/consumidor_fifos_azules.sv
// -----------------------------------------------------------------------------
// consumidor_fifos_azules
//
// Drains the four blue output FIFOs (p0..p3) through an arbiter into a single
// DATA_WIDTH-bit valid/ready stream, one word at a time.
// It also keeps a delivered-word counter for each port.
//
// Ports:
//   clk, reset          - rising-edge clock, asynchronous active-high reset
//   Enable              - allows new pops; an in-flight word always completes
//   fifo_empty[3:0]     - empty flag of blue FIFO k on bit k
//   data_in_p0..p3      - FIFO read data, valid the cycle after pop
//   pop[3:0]            - one-hot, one-cycle pop to the selected FIFO
//   data_out, valid_out - output word and its valid flag
//   ready_in            - downstream accepts data_out
//   req, idx            - counter read request and counter index
//   salida_contador     - counter read value
//   valid_contador      - salida_contador valid
//   idle                - no data held, no pending work
//
// Optional feature (macro STRICT_PRIORITY_EN):
//   defined   - fixed priority, lowest-index non-empty port wins
//   undefined - round-robin starting from the port after the last delivered one
// -----------------------------------------------------------------------------
module consumidor_fifos_azules #(
  parameter int DATA_WIDTH = 12,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Enable,
  input  logic [3:0]            fifo_empty,
  input  logic [DATA_WIDTH-1:0] data_in_p0,
  input  logic [DATA_WIDTH-1:0] data_in_p1,
  input  logic [DATA_WIDTH-1:0] data_in_p2,
  input  logic [DATA_WIDTH-1:0] data_in_p3,
  output logic [3:0]            pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  input  logic                  ready_in,
  input  logic                  req,
  input  logic [1:0]            idx,
  output logic [CNT_WIDTH-1:0]  salida_contador,
  output logic                  valid_contador,
  output logic                  idle
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_POP   = 2'd1,
    ST_LATCH = 2'd2,
    ST_SEND  = 2'd3
  } state_t;

  state_t                state_q;
  logic [1:0]            sel_q;
  logic [1:0]            rr_q;
  logic [3:0]            pop_q;
  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  valid_out_q;
  logic [CNT_WIDTH-1:0]  cnt_q [4];
  logic [CNT_WIDTH-1:0]  salida_q;
  logic                  valid_cnt_q;
  logic                  idle_q;

  logic [1:0]            base_d;
  logic [2:0]            pick_d;
  logic                  pick_valid_d;
  logic [1:0]            pick_idx_d;
  logic [DATA_WIDTH-1:0] sel_data_d;
  logic                  handshake_d;

  // First non-empty port searching upward from base, wrapping 3->0.
  // Result is {found, port}. Scanning from the far end lets the closest
  // candidate overwrite the others.
  function automatic logic [2:0] pick_port(input logic [3:0] empty,
                                           input logic [1:0] base);
    logic [2:0] res;
    logic [1:0] cand;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      cand = base + 2'(i);
      if (!empty[cand]) begin
        res = {1'b1, cand};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // One-hot decode of a port index.
  function automatic logic [3:0] port_onehot(input logic [1:0] p);
    logic [3:0] oh;
    case (p)
      2'd0:    oh = 4'b0001;
      2'd1:    oh = 4'b0010;
      2'd2:    oh = 4'b0100;
      2'd3:    oh = 4'b1000;
      default: oh = 4'b0000;
    endcase
    return oh;
  endfunction

  assign handshake_d = (state_q == ST_SEND) & valid_out_q & ready_in;

  // Arbiter: on the handshake edge the new pointer (sel+1) is not yet in
  // rr_q, so the search base is taken from sel_q directly.
  always_comb begin
    base_d = rr_q;
`ifdef STRICT_PRIORITY_EN
    base_d = 2'd0;
`else
    if (state_q == ST_SEND) begin
      base_d = sel_q + 2'd1;
    end else begin
      base_d = rr_q;
    end
`endif
    pick_d       = pick_port(fifo_empty, base_d);
    pick_valid_d = pick_d[2];
    pick_idx_d   = pick_d[1:0];
  end

  // Read-data mux for the selected port.
  always_comb begin
    case (sel_q)
      2'd0:    sel_data_d = data_in_p0;
      2'd1:    sel_data_d = data_in_p1;
      2'd2:    sel_data_d = data_in_p2;
      2'd3:    sel_data_d = data_in_p3;
      default: sel_data_d = '0;
    endcase
  end

  // Main FSM. pop is registered and set on entry to POP, so it is high only
  // during the POP cycle and never depends combinationally on the inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      sel_q       <= 2'd0;
      rr_q        <= 2'd0;
      pop_q       <= 4'b0000;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (Enable && pick_valid_d) begin
            sel_q   <= pick_idx_d;
            pop_q   <= port_onehot(pick_idx_d);
            state_q <= ST_POP;
          end else begin
            pop_q   <= 4'b0000;
            state_q <= ST_IDLE;
          end
        end
        ST_POP: begin
          pop_q   <= 4'b0000;
          state_q <= ST_LATCH;
        end
        ST_LATCH: begin
          data_out_q  <= sel_data_d;
          valid_out_q <= 1'b1;
          state_q     <= ST_SEND;
        end
        ST_SEND: begin
          if (handshake_d) begin
            valid_out_q <= 1'b0;
            rr_q        <= sel_q + 2'd1;
            if (Enable && pick_valid_d) begin
              sel_q   <= pick_idx_d;
              pop_q   <= port_onehot(pick_idx_d);
              state_q <= ST_POP;
            end else begin
              pop_q   <= 4'b0000;
              state_q <= ST_IDLE;
            end
          end else begin
            pop_q   <= 4'b0000;
            state_q <= ST_SEND;
          end
        end
        default: begin
          pop_q       <= 4'b0000;
          valid_out_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  // Per-port delivered-word counters, wrapping at 2^CNT_WIDTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
    end else if (handshake_d) begin
      cnt_q[sel_q] <= cnt_q[sel_q] + CNT_WIDTH'(1);
    end else begin
      cnt_q[sel_q] <= cnt_q[sel_q];
    end
  end

  // Counter read port. A read coinciding with an increment sees the old value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      salida_q    <= '0;
      valid_cnt_q <= 1'b0;
    end else if (req) begin
      salida_q    <= cnt_q[idx];
      valid_cnt_q <= 1'b1;
    end else begin
      salida_q    <= salida_q;
      valid_cnt_q <= 1'b0;
    end
  end

  // Idle flag, refreshed every cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_q <= 1'b0;
    end else begin
      idle_q <= (state_q == ST_IDLE) && (fifo_empty == 4'b1111);
    end
  end

  assign pop             = pop_q;
  assign data_out        = data_out_q;
  assign valid_out       = valid_out_q;
  assign salida_contador = salida_q;
  assign valid_contador  = valid_cnt_q;
  assign idle            = idle_q;

endmodule

// File: doc/consumidor_fifos_azules.md
Name: consumidor_fifos_azules

Overview:
- Downstream stage of the transaction layer. Drains the four blue output FIFOs (ports p0..p3) through a round-robin arbiter into one 12-bit output stream with a valid/ready handshake.
- Keeps a per-port counter of delivered words. Counters are readable through the req/idx interface used elsewhere in the design.
- Reports idle when it holds no data and has no pending work.

Parameters:
DATA_WIDTH, 12, width of each FIFO word and of data_out
CNT_WIDTH, 8, width of each per-port delivered-word counter

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  asynchronous, active-high; clears all state
Enable  input  1  high: new pops allowed; low: the in-flight word finishes, no new pop starts
fifo_empty  input  4  empty flag of blue FIFO k on bit k
data_in_p0  input  DATA_WIDTH  read data of blue FIFO 0
data_in_p1  input  DATA_WIDTH  read data of blue FIFO 1
data_in_p2  input  DATA_WIDTH  read data of blue FIFO 2
data_in_p3  input  DATA_WIDTH  read data of blue FIFO 3
pop  output  4  one-hot pop to blue FIFOs, one cycle wide
data_out  output  DATA_WIDTH  output word
valid_out  output  1  data_out valid
ready_in  input  1  downstream accepts data_out
req  input  1  counter read request
idx  input  2  counter index for req
salida_contador  output  CNT_WIDTH  counter read value
valid_contador  output  1  salida_contador valid
idle  output  1  block idle

Behaviour:
- Reset, asynchronous and active-high, drives:
  - state=IDLE, pop=0, data_out=0, valid_out=0;
  - all counters=0, rr pointer=0, sel=0;
  - salida_contador=0, valid_contador=0.
- FIFO contract: read data is valid on the cycle after pop is asserted (1-cycle registered read).
- Round-robin eligibility: port k is eligible when fifo_empty[k]=0. The search starts at the rr pointer and goes upward, wrapping 3->0. The first eligible port becomes sel.
- FSM states: IDLE, POP, LATCH, SEND.
  - IDLE: if Enable=1 and any port is eligible, register sel and go to POP; otherwise stay.
  - POP: pop[sel]=1 for exactly this cycle (decoded from state and sel registers, no combinational path from inputs). Next state is LATCH.
  - LATCH: data_out <= data_in_p[sel] at the end of the cycle. Next state is SEND.
  - SEND: valid_out=1 and data_out is held stable until ready_in=1.
    - On a handshake (valid_out&ready_in): counter[sel] += 1 (wraps modulo 2^CNT_WIDTH) and the rr pointer becomes sel+1 (mod 4).
    - On the same edge: if Enable=1 and a port is eligible (searching from the new pointer), register the new sel and go directly to POP. Otherwise go to IDLE.
- Throughput: with ready_in held at 1, one word every 3 cycles. Latency from POP to valid_out is 2 cycles.
- Enable falling while in POP/LATCH/SEND: the current word completes normally and no further pop is issued.
- ready_in low in SEND: the block stalls indefinitely with no pop and no counter change.
- fifo_empty is sampled only in IDLE and on the SEND handshake edge. A port that empties after it has been selected is still popped; this is the FIFO's responsibility.
- Counter read:
  - req=1 at edge N gives salida_contador=counter[idx] and valid_contador=1 after edge N.
  - req=0 gives valid_contador=0 and salida_contador keeps its last value.
  - A read and an increment of the same counter on the same edge returns the pre-increment value.
- idle=1 when state=IDLE and fifo_empty=4'b1111. It is registered and updated every cycle.
- Reset mid-operation: a word popped but not yet delivered is lost and is not counted.

Optional Feature:
- Macro STRICT_PRIORITY_EN.
- Defined: the arbiter ignores the rr pointer and always selects the lowest-index eligible port (p0 highest priority). The rr pointer is still maintained but unused.
- Undefined: round-robin as described above.

Test Plan:
- Reset: assert reset mid-SEND with data_out=0xABC. Required: pop=0, valid_out=0, data_out=0 and all counters 0 immediately (asynchronous), idle=1 once fifo_empty=1111.
- Single port: p2 holds 0x123 and 0x456, others empty, ready_in=1. Required: pop=0100 twice, data_out 0x123 then 0x456, words 3 cycles apart; req with idx=2 then returns 2.
- Round-robin fairness: all four ports hold 2 words each (port k holds 0xk00 and 0xk01). Required output order 000,100,200,300,001,101,201,301; counters 2,2,2,2.
- Backpressure: ready_in=0 for 10 cycles while in SEND. Required: data_out stable, valid_out=1, no pop; on ready_in=1 exactly one count increments.
- Enable drop: Enable falls during POP. Required: that word is delivered, then FSM returns to IDLE with no further pop while FIFOs remain non-empty; Enable=1 resumes.
- STRICT_PRIORITY_EN defined: p0 and p3 both non-empty (3 words each). Required: all p0 words are delivered before any p3 word.
